// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID/EX/MEM hazard inputs and stall/flush/freeze outputs of the sequencing controller
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
  logic forwardEn, idValid, twoSrc, exWbEn, exMemRead, memWbEn, memReq, memReady, branchTaken;
  logic [3:0] src1, src2, exDest, memDest;
  logic hazard, freeze, flush, memError;
  logic [CNT_W-1:0] stallCnt;
  modport master (
    output forwardEn, idValid, twoSrc, exWbEn, exMemRead, memWbEn, memReq, memReady, branchTaken,
    output src1, src2, exDest, memDest,
    input hazard, freeze, flush, memError, stallCnt
  );
  modport slave (
    input forwardEn, idValid, twoSrc, exWbEn, exMemRead, memWbEn, memReq, memReady, branchTaken,
    input src1, src2, exDest, memDest,
    output hazard, freeze, flush, memError, stallCnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hold/bubble, SRAM-wait freeze with watchdog abort, and flush control
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
  state_t state;
  logic [WD_W-1:0] wd_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic mem_error, m1, m2, n1, n2, raw, freeze, hazard;
  always_comb begin
    m1 = bus.exWbEn && bus.exDest == bus.src1;
    m2 = bus.twoSrc && bus.exWbEn && bus.exDest == bus.src2;
    n1 = bus.memWbEn && bus.memDest == bus.src1;
    n2 = bus.twoSrc && bus.memWbEn && bus.memDest == bus.src2;
    raw = bus.idValid && (bus.forwardEn ? bus.exMemRead && (m1 || m2) : (m1 || m2 || n1 || n2));
    // the abort cycle releases the pipe even if memReq is still held
    freeze = rst && bus.memReq && !bus.memReady && state != ABORT;
    hazard = raw && !freeze;
  end
  assign bus.hazard = hazard;
  assign bus.freeze = freeze;
  assign bus.flush = bus.branchTaken && !freeze;
  assign bus.memError = mem_error;
  assign bus.stallCnt = stall_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wd_cnt <= '0;
      mem_error <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if ((hazard || freeze) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        IDLE: if (bus.memReq && !bus.memReady) begin
          state <= BUSY;
          wd_cnt <= '0;
        end
        BUSY: if (!bus.memReq || bus.memReady) state <= IDLE;
          else if (wd_cnt == WD_W'(TIMEOUT - 1)) state <= ABORT;
          else wd_cnt <= wd_cnt + 1'b1;
        default: begin
          state <= IDLE;
          mem_error <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed plan plus random stimulus against a cycle-count reference model
module tb_hazard_stall_ctrl;
  localparam int TO = 8;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();
  hazard_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int m_run = 0;
  int m_cnt = 0;
  bit m_abort = 0;
  bit m_err = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic bit exp_raw();
    bit e1 = bus.exWbEn && bus.exDest == bus.src1;
    bit e2 = bus.twoSrc && bus.exWbEn && bus.exDest == bus.src2;
    bit w1 = bus.memWbEn && bus.memDest == bus.src1;
    bit w2 = bus.twoSrc && bus.memWbEn && bus.memDest == bus.src2;
    if (!bus.idValid) return 0;
    return bus.forwardEn ? (bus.exMemRead && (e1 || e2)) : (e1 || e2 || w1 || w2);
  endfunction
  task automatic m_reset();
    m_run = 0;
    m_cnt = 0;
    m_abort = 0;
    m_err = 0;
  endtask
  task automatic clear();
    {bus.forwardEn, bus.idValid, bus.twoSrc, bus.exWbEn, bus.exMemRead} = '0;
    {bus.memWbEn, bus.memReq, bus.memReady, bus.branchTaken} = '0;
    {bus.src1, bus.src2, bus.exDest, bus.memDest} = '0;
  endtask
  // inputs are already applied; check mid-cycle, then advance the model across the edge
  task automatic cycle(string tag);
    bit ef, eh;
    #1;
    ef = rst && bus.memReq && !bus.memReady && !m_abort;
    eh = exp_raw() && !ef;
    check({tag, ".hazard"}, bus.hazard, eh);
    check({tag, ".freeze"}, bus.freeze, ef);
    check({tag, ".flush"}, bus.flush, bus.branchTaken && !ef);
    check({tag, ".memError"}, bus.memError, m_err);
    check({tag, ".stallCnt"}, bus.stallCnt, m_cnt);
    @(posedge clk);
    if (rst) begin
      if ((eh || ef) && m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_abort) begin
        m_abort = 0;
        m_err = 1;
        m_run = 0;
      end else if (ef) begin
        m_run++;
        if (m_run == TO + 1) begin
          m_abort = 1;
          m_run = 0;
        end
      end else m_run = 0;
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    m_reset();
    cycle("rst");
    rst = 1'b1;
  endtask
  initial begin
    clear();
    m_reset();
    @(posedge clk);
    cycle("reset");
    rst = 1'b1;
    // load-use with forwarding, then the bubble moves the load to MEM
    bus.forwardEn = 1; bus.exMemRead = 1; bus.exWbEn = 1; bus.exDest = 3; bus.src1 = 3; bus.idValid = 1;
    #1 check("loaduse_hazard", bus.hazard, 1);
    cycle("loaduse");
    bus.exMemRead = 0; bus.exWbEn = 0; bus.memWbEn = 1; bus.memDest = 3;
    #1 check("loaduse_released", bus.hazard, 0);
    cycle("loaduse_mem");
    bus.exMemRead = 0; bus.exWbEn = 1; bus.memWbEn = 0;
    cycle("noload");
    // no forwarding, src2 dependency on MEM
    clear();
    bus.idValid = 1; bus.memWbEn = 1; bus.memDest = 5; bus.src2 = 5; bus.src1 = 0; bus.twoSrc = 1;
    #1 check("nofwd_two_src", bus.hazard, 1);
    cycle("nofwd_two");
    bus.twoSrc = 0;
    cycle("nofwd_one");
    // SRAM wait with ready on cycle 4
    clear();
    do_reset();
    bus.memReq = 1;
    for (int i = 0; i < 4; i++) cycle("sram_wait");
    bus.memReady = 1;
    cycle("sram_ready");
    bus.memReq = 0; bus.memReady = 0;
    #1 check("sram_stallcnt", bus.stallCnt, 4);
    cycle("sram_idle");
    bus.memReq = 1; bus.memReady = 1;
    cycle("sram_single");
    // freeze masks hazard and flush
    bus.memReady = 0;
    cycle("mask_enter");
    bus.forwardEn = 1; bus.exMemRead = 1; bus.exWbEn = 1; bus.exDest = 7; bus.src1 = 7;
    bus.idValid = 1; bus.branchTaken = 1;
    #1 check("mask_flush", bus.flush, 0);
    cycle("mask_busy");
    cycle("mask_busy2");
    bus.memReady = 1;
    #1 check("mask_flush_after", bus.flush, 1);
    cycle("mask_ready");
    // watchdog abort
    clear();
    do_reset();
    bus.memReq = 1;
    for (int i = 0; i < TO + 3; i++) cycle("wd_abort");
    bus.memReq = 0;
    cycle("wd_after");
    check("wd_error_set", bus.memError, 1);
    cycle("wd_sticky");
    // ready on the compare cycle completes normally
    do_reset();
    bus.memReq = 1;
    for (int i = 0; i < TO; i++) cycle("wd_edge");
    bus.memReady = 1;
    cycle("wd_edge_ready");
    bus.memReq = 0; bus.memReady = 0;
    cycle("wd_edge_idle");
    check("wd_edge_no_error", bus.memError, 0);
    // reset in mid-BUSY
    bus.memReq = 1;
    for (int i = 0; i < 4; i++) cycle("mid_busy");
    rst = 1'b0;
    m_reset();
    #1;
    check("mid_rst_freeze", bus.freeze, 0);
    check("mid_rst_cnt", bus.stallCnt, 0);
    cycle("mid_rst");
    rst = 1'b1;
    // counter saturation
    clear();
    bus.exWbEn = 1; bus.exDest = 1; bus.src1 = 1; bus.idValid = 1;
    for (int i = 0; i < 20; i++) cycle("sat");
    check("sat_value", bus.stallCnt, 15);
    // random traffic
    clear();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.memReq = ~bus.memReq;
      bus.memReady = $urandom_range(0, 5) == 0;
      bus.forwardEn = $urandom_range(0, 1) == 1;
      bus.idValid = $urandom_range(0, 3) != 0;
      bus.twoSrc = $urandom_range(0, 1) == 1;
      bus.exWbEn = $urandom_range(0, 1) == 1;
      bus.exMemRead = $urandom_range(0, 1) == 1;
      bus.memWbEn = $urandom_range(0, 1) == 1;
      bus.branchTaken = $urandom_range(0, 3) == 0;
      bus.src1 = 4'($urandom_range(0, 3));
      bus.src2 = 4'($urandom_range(0, 3));
      bus.exDest = 4'($urandom_range(0, 3));
      bus.memDest = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        m_reset();
      end else rst = 1'b1;
      cycle("rand");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
